mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one memory port between the CPU fetch port (iram_*) and load/store port (dram_*).
//  Sits between CPU and the single unified memory model in top; one outstanding transaction.
//  Arbitration: load/store has priority; fetch is protected by a starvation limit.
//  A response watchdog terminates hung transactions with an error pulse.
// PARAMETERS
//  AW            32    address width
//  DW            32    data width (mask width DW/8)
//  IF_STARVE_MAX 4     consecutive ls grants while if_req pending before fetch is forced
//  TIMEOUT_CYC   255   cycles in RESP before abort (8-bit counter; 0 disables watchdog)
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     asynchronous reset, active-low (0 = reset)
//  if_req     in   1     fetch request, held until if_gnt
//  if_addr    in   AW    fetch address
//  if_gnt     out  1     fetch accepted (1-cycle pulse)
//  if_rvalid  out  1     fetch data valid (1-cycle pulse)
//  if_rdata   out  DW    instruction word
//  ls_req     in   1     load/store request, held until ls_gnt
//  ls_wen     in   1     1 = store
//  ls_addr    in   AW    data address
//  ls_wdata   in   DW    store data
//  ls_wmask   in   DW/8  byte-write mask
//  ls_gnt     out  1     ls accepted (1-cycle pulse)
//  ls_rvalid  out  1     load data / store ack (1-cycle pulse)
//  ls_rdata   out  DW    load data; 0 for stores
//  mem_en     out  1     memory command valid
//  mem_wen    out  1     command is a write
//  mem_addr   out  AW    command address
//  mem_wdata  out  DW    write data
//  mem_wmask  out  DW/8  write mask
//  mem_ready  in   1     memory accepts command this cycle
//  mem_rvalid in   1     memory response (reads and writes)
//  mem_rdata  in   DW    read data
//  err        out  1     watchdog abort (1-cycle pulse)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; starve and watchdog counters 0. Reset mid-transaction drops it, no rvalid.
//  FSM states: IDLE, REQ, RESP. All mem_* outputs and *_rvalid/*_rdata/err are registered.
//  IDLE: if ls_req and not forced-fetch -> ls_gnt=1; else if if_req -> if_gnt=1 (combinational, same cycle).
//    On grant: latch owner + command into mem_* regs; next cycle mem_en=1, state REQ.
//    ls_gnt, if_gnt are never both high; neither is high outside IDLE.
//  Forced-fetch: starve counter increments on each ls grant while if_req=1; clears on if grant
//    or when if_req=0 in IDLE. Counter==IF_STARVE_MAX -> next arbitration grants fetch.
//  REQ: hold mem_* stable while mem_ready=0. mem_ready=1 -> mem_en=0 next cycle, state RESP.
//    mem_rvalid during REQ is ignored.
//  RESP: mem_rvalid=1 -> owner's *_rvalid=1 next cycle, rdata=mem_rdata (ls store: ls_rdata=0),
//    state IDLE. New arbitration possible in the cycle *_rvalid is high.
//  Watchdog: counts cycles in RESP. Reaching TIMEOUT_CYC -> err=1 + owner *_rvalid=1 with rdata=0, IDLE.
//    A late mem_rvalid arriving in IDLE is discarded.
//  Best-case latency: req at cycle N -> gnt N, mem_en N+1 (ready N+1), mem_rvalid N+2, *_rvalid N+3.
//  *_rdata holds its last value between pulses.
// TESTING
//  1 Reset: rst=0 mid-RESP -> all outputs 0 next edge; no *_rvalid after release.
//  2 Single fetch: if_req, addr 0x80000000; ready at once; rdata 0x00100093 -> if_rvalid at N+3 with 0x00100093.
//  3 Collision: if_req and ls_req both in IDLE -> ls_gnt first; if_gnt on next IDLE; order ls then if.
//  4 Starvation: ls_req held high, if_req high -> 4 ls grants then if_gnt; counter restarts after.
//  5 Store: ls_wen=1, wmask 4'b0011, wdata 0xAABBCCDD; mem_ready low 3 cycles -> mem_* stable; ls_rvalid, ls_rdata=0.
//  6 Timeout: TIMEOUT_CYC=8, mem_rvalid never -> err and if_rvalid pulse 8 cycles into RESP, rdata 0; late rvalid ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store.
// Load/store wins arbitration; a starvation limit and a response watchdog apply.
module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int IF_STARVE_MAX = 4,
  parameter int TIMEOUT_CYC   = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            ls_req,
  input  logic            ls_wen,
  input  logic [AW-1:0]   ls_addr,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wmask,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [DW-1:0]   ls_rdata,
  output logic            mem_en,
  output logic            mem_wen,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_ready,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  localparam logic [7:0] STARVE_LIM = 8'(IF_STARVE_MAX);
  localparam logic [7:0] WD_LIM     = 8'(TIMEOUT_CYC);
  localparam logic [7:0] WD_LAST    = 8'(TIMEOUT_CYC - 1);
  localparam bit         WD_ON      = (TIMEOUT_CYC != 0);

  state_t     state;
  logic       owner_ls;
  logic       owner_wen;
  logic [7:0] starve;
  logic [7:0] wd;
  logic       forced;
  logic       idle;

  always_comb begin
    idle   = (state == IDLE);
    forced = if_req && (starve == STARVE_LIM);
    ls_gnt = idle && ls_req && !forced;
    if_gnt = idle && if_req && !ls_gnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner_ls  <= 1'b0;
      owner_wen <= 1'b0;
      starve    <= '0;
      wd        <= '0;
      mem_en    <= 1'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      err       <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          wd <= '0;
          if (ls_gnt) begin
            owner_ls  <= 1'b1;
            owner_wen <= ls_wen;
            mem_en    <= 1'b1;
            mem_wen   <= ls_wen;
            mem_addr  <= ls_addr;
            mem_wdata <= ls_wdata;
            mem_wmask <= ls_wmask;
            starve    <= if_req ? starve + 8'd1 : '0;
            state     <= REQ;
          end else if (if_gnt) begin
            owner_ls  <= 1'b0;
            owner_wen <= 1'b0;
            mem_en    <= 1'b1;
            mem_wen   <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wmask <= '0;
            starve    <= '0;
            state     <= REQ;
          end else if (!if_req) begin
            starve <= '0;
          end
        end
        REQ: begin
          if (mem_ready) begin
            mem_en <= 1'b0;
            state  <= RESP;
          end
        end
        RESP: begin
          if (mem_rvalid) begin
            state <= IDLE;
            if (owner_ls) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= owner_wen ? '0 : mem_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end else if (WD_ON && WD_LIM != 8'd0 && wd == WD_LAST) begin
            // Abort: answer the owner with zero data so the CPU never hangs.
            state <= IDLE;
            err   <= 1'b1;
            if (owner_ls) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= '0;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= '0;
            end
          end else begin
            wd <= wd + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Expected responses are queued at grant time and matched on each rvalid pulse.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_wen = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_wmask = '0;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        err;

  mem_port_arbiter #(
    .AW(32), .DW(32), .IF_STARVE_MAX(4), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_wmask(ls_wmask), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ls;
    logic [31:0] data;
    bit          er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon();
    exp_t e;
    if (if_rvalid || ls_rvalid || err) begin
      if (sb.size() == 0) begin
        chk("rv_unexpected", 32'({if_rvalid, ls_rvalid, err}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rv_ls", 32'(ls_rvalid), 32'(e.ls));
        chk("rv_if", 32'(if_rvalid), 32'(!e.ls));
        chk("rdata", e.ls ? ls_rdata : if_rdata, e.data);
        chk("err", 32'(err), 32'(e.er));
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mon();
  endtask

  task automatic grant(input bit ls, input bit wen,
                       input logic [31:0] rd, input bit er);
    exp_t e;
    #1;
    chk("ls_gnt", 32'(ls_gnt), 32'(ls));
    chk("if_gnt", 32'(if_gnt), 32'(!ls));
    e.ls   = ls;
    e.er   = er;
    e.data = (er || (ls && wen)) ? 32'd0 : rd;
    sb.push_back(e);
    tick();
  endtask

  task automatic chk_cmd(input bit ls, input bit wen, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] wm);
    chk("mem_en", 32'(mem_en), 32'd1);
    chk("mem_wen", 32'(mem_wen), 32'(wen));
    chk("mem_addr", mem_addr, a);
    if (ls && wen) begin
      chk("mem_wdata", mem_wdata, wd);
      chk("mem_wmask", 32'(mem_wmask), 32'(wm));
    end
    chk("gnt_busy", 32'({ls_gnt, if_gnt}), 32'd0);
  endtask

  task automatic finish_txn(input bit ls, input bit wen,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] wm, input logic [31:0] rd,
                            input int delay);
    for (int i = 0; i < delay; i++) begin
      chk_cmd(ls, wen, a, wd, wm);
      tick();
    end
    chk_cmd(ls, wen, a, wd, wm);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("mem_en_off", 32'(mem_en), 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    tick();
    mem_rvalid = 1'b0;
    chk(ls ? "ls_rvalid" : "if_rvalid",
        32'(ls ? ls_rvalid : if_rvalid), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({if_gnt, if_rvalid, ls_gnt, ls_rvalid,
                  mem_en, mem_wen, err}), 32'd0);
    chk({tag, "_data"}, if_rdata | ls_rdata | mem_addr | mem_wdata, 32'd0);
  endtask

  initial begin
    int k;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    tick();

    // single fetch, best-case latency
    if_addr = 32'h8000_0000;
    if_req  = 1'b1;
    grant(1'b0, 1'b0, 32'h0010_0093, 1'b0);
    if_req = 1'b0;
    finish_txn(1'b0, 1'b0, 32'h8000_0000, '0, '0, 32'h0010_0093, 0);
    chk("fetch_data", if_rdata, 32'h0010_0093);

    // reset mid-RESP drops the transaction
    if_addr = 32'h8000_0004;
    if_req  = 1'b1;
    grant(1'b0, 1'b0, 32'h0, 1'b0);
    if_req    = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    sb.delete();
    tick();
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    chk("rst_no_rv", 32'({if_rvalid, ls_rvalid}), 32'd0);
    tick();
    chk("rst_no_rv2", 32'({if_rvalid, ls_rvalid}), 32'd0);

    // collision: load first, fetch in the rvalid cycle
    ls_addr = 32'h0000_1000;
    ls_wen  = 1'b0;
    ls_req  = 1'b1;
    if_addr = 32'h8000_0008;
    if_req  = 1'b1;
    grant(1'b1, 1'b0, 32'h1122_3344, 1'b0);
    ls_req = 1'b0;
    finish_txn(1'b1, 1'b0, 32'h0000_1000, '0, '0, 32'h1122_3344, 0);
    grant(1'b0, 1'b0, 32'h0000_0013, 1'b0);
    if_req = 1'b0;
    finish_txn(1'b0, 1'b0, 32'h8000_0008, '0, '0, 32'h0000_0013, 0);

    // starvation: four load grants then a forced fetch, twice
    ls_addr = 32'h0000_2000;
    if_addr = 32'h8000_000C;
    ls_req  = 1'b1;
    if_req  = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        grant(1'b1, 1'b0, 32'h100 + 32'(i) + 32'(r * 16), 1'b0);
        finish_txn(1'b1, 1'b0, 32'h0000_2000, '0, '0,
                   32'h100 + 32'(i) + 32'(r * 16), 0);
      end
      grant(1'b0, 1'b0, 32'hA0 + 32'(r), 1'b0);
      finish_txn(1'b0, 1'b0, 32'h8000_000C, '0, '0, 32'hA0 + 32'(r), 0);
    end
    ls_req = 1'b0;
    if_req = 1'b0;
    tick();

    // store with a stalled memory
    ls_addr  = 32'h0000_3000;
    ls_wen   = 1'b1;
    ls_wdata = 32'hAABB_CCDD;
    ls_wmask = 4'b0011;
    ls_req   = 1'b1;
    grant(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0);
    ls_req = 1'b0;
    ls_wen = 1'b0;
    finish_txn(1'b1, 1'b1, 32'h0000_3000, 32'hAABB_CCDD, 4'b0011,
               32'hFFFF_FFFF, 3);
    chk("store_rdata", ls_rdata, 32'd0);
    tick();

    // watchdog abort, late response discarded
    if_addr = 32'h8000_0010;
    if_req  = 1'b1;
    grant(1'b0, 1'b0, 32'h0, 1'b1);
    if_req = 1'b0;
    chk_cmd(1'b0, 1'b0, 32'h8000_0010, '0, '0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    k = 0;
    while (!(err || if_rvalid) && k < 40) begin
      tick();
      k++;
    end
    chk("wd_cycles", 32'(k), 32'(TO));
    chk("wd_if_rvalid", 32'(if_rvalid), 32'd1);
    chk("wd_rdata", if_rdata, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chk("late_rv", 32'({if_rvalid, ls_rvalid, err}), 32'd0);
    tick();
    chk("late_rv2", 32'({if_rvalid, ls_rvalid, err}), 32'd0);
    chk("late_rdata", if_rdata, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
